// File: rtl/riscv_pkg.sv
// Shared definitions for the 8-bit RISC-V pipeline:
// opcodes, ALU op encodings and the ID/EX register bundle.
package riscv_pkg;

    localparam int XLEN   = 8;
    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [1:0]        alu_op;
        logic [9:0]        funct;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } id_ex_t;

    // Full-width sign-extended immediate; callers keep the low XLEN bits.
    function automatic logic [31:0] imm_gen(input logic [31:0] i);
        logic [31:0] r;
        r = '0;
        unique case (i[6:0])
            OPC_LOAD:   r = {{20{i[31]}}, i[31:20]};
            OPC_STORE:  r = {{20{i[31]}}, i[31:25], i[11:7]};
            OPC_BRANCH: r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/main_decoder.sv
// Main control decoder: opcode to control bits.
// Unknown opcodes decode to all-zero control with legal=0.
module main_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       branch,
    output logic       legal
);

    always_comb begin
        alu_op     = ALUOP_MEM;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        legal      = 1'b0;
        unique case (1'b1)
            (opcode == OPC_RTYPE): begin
                alu_op    = ALUOP_RTYPE;
                reg_write = 1'b1;
                legal     = 1'b1;
            end
            (opcode == OPC_LOAD): begin
                alu_op     = ALUOP_MEM;
                alu_src    = 1'b1;
                mem_read   = 1'b1;
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                legal      = 1'b1;
            end
            (opcode == OPC_STORE): begin
                alu_op    = ALUOP_MEM;
                alu_src   = 1'b1;
                mem_write = 1'b1;
                legal     = 1'b1;
            end
            (opcode == OPC_BRANCH): begin
                alu_op = ALUOP_BRANCH;
                branch = 1'b1;
                legal  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX boundary: decode, immediate gen, load-use hazard
// detection and the ID/EX pipeline register.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              load_use_stall,
    output logic              ex_valid,
    output logic [1:0]        ex_alu_op,
    output logic [9:0]        ex_funct,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd
);

    logic [6:0]        opcode;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [1:0]        dec_alu_op;
    logic              dec_alu_src, dec_reg_write, dec_mem_read;
    logic              dec_mem_write, dec_mem_to_reg, dec_branch;
    logic              dec_legal, uses_rs2, live;
    logic [31:0]       imm_full;
    id_ex_t            ex_q, ex_d;

    assign opcode   = id_instr[6:0];
    assign id_rs1   = id_instr[19:15];
    assign id_rs2   = id_instr[24:20];
    assign id_rd    = id_instr[11:7];
    assign imm_full = imm_gen(id_instr);
    assign uses_rs2 = (opcode == OPC_RTYPE) || (opcode == OPC_STORE)
                   || (opcode == OPC_BRANCH);

    main_decoder u_dec (
        .opcode     (opcode),
        .alu_op     (dec_alu_op),
        .alu_src    (dec_alu_src),
        .reg_write  (dec_reg_write),
        .mem_read   (dec_mem_read),
        .mem_write  (dec_mem_write),
        .mem_to_reg (dec_mem_to_reg),
        .branch     (dec_branch),
        .legal      (dec_legal)
    );

    always_comb begin
        load_use_stall = id_valid && ex_q.valid && ex_q.mem_read
                      && (ex_q.rd != '0)
                      && ((ex_q.rd == id_rs1)
                          || (uses_rs2 && (ex_q.rd == id_rs2)));
    end

    assign live = id_valid && dec_legal;

    always_comb begin
        ex_d = ex_q;
        if (!ex_stall) begin
            if (flush || load_use_stall) begin
                ex_d = '0;
            end else begin
                ex_d.valid      = live;
                ex_d.alu_op     = live ? dec_alu_op : ALUOP_MEM;
                ex_d.funct      = {id_instr[31:25], id_instr[14:12]};
                ex_d.alu_src    = live && dec_alu_src;
                ex_d.reg_write  = live && dec_reg_write;
                ex_d.mem_read   = live && dec_mem_read;
                ex_d.mem_write  = live && dec_mem_write;
                ex_d.mem_to_reg = live && dec_mem_to_reg;
                ex_d.branch     = live && dec_branch;
                ex_d.rs1_data   = id_rs1_data;
                ex_d.rs2_data   = id_rs2_data;
                ex_d.imm        = imm_full[XLEN-1:0];
                ex_d.rs1        = id_rs1;
                ex_d.rs2        = id_rs2;
                ex_d.rd         = id_rd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign ex_valid      = ex_q.valid;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_funct      = ex_q.funct;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_branch     = ex_q.branch;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, hazards,
// bubbles, flush and stall behaviour.
module tb_id_ex_stage;
    import riscv_pkg::*;

    localparam logic [31:0] I_ADD3  = 32'h002081B3;
    localparam logic [31:0] I_SUB3  = 32'h402081B3;
    localparam logic [31:0] I_LD5   = 32'h0040B283;
    localparam logic [31:0] I_ADD65 = 32'h00228333;
    localparam logic [31:0] I_LD0   = 32'h0000B003;
    localparam logic [31:0] I_ADD60 = 32'h00200333;
    localparam logic [31:0] I_SD7   = 32'hFE713FA3;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_ADDI  = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [31:0]       id_instr;
    logic [XLEN-1:0]   id_rs1_data, id_rs2_data;
    logic              ex_stall, flush;
    logic              load_use_stall, ex_valid;
    logic [1:0]        ex_alu_op;
    logic [9:0]        ex_funct;
    logic              ex_alu_src, ex_reg_write, ex_mem_read;
    logic              ex_mem_write, ex_mem_to_reg, ex_branch;
    logic [XLEN-1:0]   ex_rs1_data, ex_rs2_data, ex_imm;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .ex_stall       (ex_stall),
        .flush          (flush),
        .load_use_stall (load_use_stall),
        .ex_valid       (ex_valid),
        .ex_alu_op      (ex_alu_op),
        .ex_funct       (ex_funct),
        .ex_alu_src     (ex_alu_src),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .ex_branch      (ex_branch),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_rd          (ex_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic put(input logic [31:0] ins);
        id_instr = ins;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b1; id_instr = I_ADD3;
        id_rs1_data = 8'h05; id_rs2_data = 8'h03;
        ex_stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("rst_valid", ex_valid, 0);
        chk("rst_aluop", ex_alu_op, 0);
        chk("rst_funct", ex_funct, 0);
        chk("rst_rd", ex_rd, 0);
        chk("rst_regw", ex_reg_write, 0);
        chk("rst_rs1d", ex_rs1_data, 0);
        chk("rst_lus", load_use_stall, 0);

        rst_n = 1'b1;
        put(I_SUB3);
        step();
        chk("sub_valid", ex_valid, 1);
        chk("sub_aluop", ex_alu_op, 2);
        chk("sub_funct", ex_funct, 10'h100);
        chk("sub_rd", ex_rd, 3);
        chk("sub_regw", ex_reg_write, 1);
        chk("sub_rs1d", ex_rs1_data, 8'h05);
        chk("sub_rs2d", ex_rs2_data, 8'h03);
        chk("sub_imm", ex_imm, 0);
        chk("sub_alusrc", ex_alu_src, 0);

        put(I_LD5);
        step();
        chk("ld_memrd", ex_mem_read, 1);
        chk("ld_m2r", ex_mem_to_reg, 1);
        chk("ld_imm", ex_imm, 8'h04);
        chk("ld_rd", ex_rd, 5);
        put(I_ADD65);
        chk("lu_stall", load_use_stall, 1);
        step();
        chk("lu_bub_valid", ex_valid, 0);
        chk("lu_bub_regw", ex_reg_write, 0);
        chk("lu_bub_memrd", ex_mem_read, 0);
        chk("lu_clear", load_use_stall, 0);
        step();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rd", ex_rd, 6);
        chk("lu_add_rs1", ex_rs1, 5);

        put(I_LD0);
        step();
        chk("ld0_memrd", ex_mem_read, 1);
        chk("ld0_regw", ex_reg_write, 1);
        put(I_ADD60);
        chk("ld0_nostall", load_use_stall, 0);
        step();
        chk("ld0_add_valid", ex_valid, 1);
        chk("ld0_add_rd", ex_rd, 6);
        put(I_SD7);
        step();
        chk("sd_imm", ex_imm, 8'hFF);
        chk("sd_memwr", ex_mem_write, 1);
        chk("sd_regw", ex_reg_write, 0);
        chk("sd_alusrc", ex_alu_src, 1);
        chk("sd_rs2", ex_rs2, 7);

        put(I_ADDI);
        step();
        chk("illegal_valid", ex_valid, 0);
        chk("illegal_regw", ex_reg_write, 0);
        id_valid = 1'b0;
        put(I_ADD3);
        step();
        chk("novalid_valid", ex_valid, 0);
        chk("novalid_regw", ex_reg_write, 0);
        id_valid = 1'b1;

        flush = 1'b1;
        put(I_BEQ);
        step();
        chk("flush_valid", ex_valid, 0);
        chk("flush_branch", ex_branch, 0);
        flush = 1'b0;
        step();
        chk("beq_valid", ex_valid, 1);
        chk("beq_branch", ex_branch, 1);
        chk("beq_aluop", ex_alu_op, 1);
        chk("beq_imm", ex_imm, 8'h08);
        flush = 1'b1; ex_stall = 1'b1;
        put(I_SUB3);
        step();
        chk("fst_branch", ex_branch, 1);
        chk("fst_valid", ex_valid, 1);
        chk("fst_imm", ex_imm, 8'h08);
        flush = 1'b0;

        for (int i = 0; i < 3; i++) begin
            put(i == 0 ? I_ADD3 : (i == 1 ? I_LD5 : I_SD7));
            id_rs1_data = 8'(8'h40 + i);
            step();
            chk("stall_branch", ex_branch, 1);
            chk("stall_aluop", ex_alu_op, 1);
            chk("stall_rs1d", ex_rs1_data, 8'h05);
        end
        ex_stall = 1'b0;
        put(I_ADD65);
        step();
        chk("rel_aluop", ex_alu_op, 2);
        chk("rel_rd", ex_rd, 6);
        chk("rel_branch", ex_branch, 0);
        chk("rel_rs1d", ex_rs1_data, 8'h42);

        put(I_LD5);
        step();
        put(I_ADD65);
        chk("rst_mid_lus", load_use_stall, 1);
        rst_n = 1'b0;
        step();
        chk("rst_mid_valid", ex_valid, 0);
        chk("rst_mid_memrd", ex_mem_read, 0);
        chk("rst_mid_lus0", load_use_stall, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
